// File: rtl/buffer_write_arbiter_if.sv
// Bundle of producer streams and the FIFO write port seen by buffer_write_arbiter.
// "master" is the environment side (producers + FIFO); "slave" is the arbiter.
interface buffer_write_arbiter_if #(
  parameter int NUM_REQ = 4
);
  localparam int GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [NUM_REQ-1:0]    req_valid;
  logic [NUM_REQ*32-1:0] req_data;
  logic [NUM_REQ-1:0]    req_last;
  logic [NUM_REQ-1:0]    req_ready;
  logic                  buf_write_enable;
  logic [31:0]           buf_write_data;
  logic                  buf_full;
  logic [NUM_REQ-1:0]    grant;
  logic [GW-1:0]         grant_id;
  logic                  busy;

  modport master (
    output req_valid, req_data, req_last, buf_full,
    input  req_ready, buf_write_enable, buf_write_data, grant, grant_id, busy
  );

  modport slave (
    input  req_valid, req_data, req_last, buf_full,
    output req_ready, buf_write_enable, buf_write_data, grant, grant_id, busy
  );
endinterface

// File: rtl/buffer_write_arbiter.sv
// Round-robin arbiter sharing the data FIFO write port between NUM_REQ producers.
// A grant is held for a burst that ends on req_last or after MAX_BURST words.
module buffer_write_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int MAX_BURST = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  buffer_write_arbiter_if.slave  bus
);
  localparam int GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CW = $clog2(MAX_BURST + 1);

  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_GRANT = 1'b1;

  logic [0:0]         r_state;
  logic [NUM_REQ-1:0] r_grant;
  logic [GW-1:0]      r_grant_id;
  logic [CW-1:0]      r_burst_cnt;

  logic               w_busy;
  logic               w_pick_hit;
  logic [GW-1:0]      w_pick_id;
  logic [NUM_REQ-1:0] w_pick_onehot;
  logic               w_own_valid;
  logic               w_own_last;
  logic [31:0]        w_own_data;
  logic               w_accept_ok;
  logic               w_xfer;
  logic               w_burst_end;

  assign w_busy = (r_state == S_GRANT);

  // Search starts just after the previous owner, so the lowest offset that is valid wins.
  always_comb begin
    logic [GW-1:0] v_idx;
    v_idx      = '0;
    w_pick_hit = 1'b0;
    w_pick_id  = r_grant_id;
    for (int k = NUM_REQ; k >= 1; k--) begin
      v_idx = GW'((int'(r_grant_id) + k) % NUM_REQ);
      if (bus.req_valid[v_idx]) begin
        w_pick_hit = 1'b1;
        w_pick_id  = v_idx;
      end
    end
  end

  assign w_pick_onehot = {{(NUM_REQ-1){1'b0}}, 1'b1} << w_pick_id;

  always_comb begin
    w_own_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (r_grant_id == GW'(i)) begin
        w_own_data = bus.req_data[32*i +: 32];
      end
    end
  end

  assign w_own_valid = bus.req_valid[r_grant_id];
  assign w_own_last  = bus.req_last[r_grant_id];

  // Nothing is accepted while the FIFO is full or while a reset is being applied.
  assign w_accept_ok = w_busy & ~bus.buf_full & ~reset;
  assign w_xfer      = w_accept_ok & w_own_valid;
  assign w_burst_end = w_xfer & (w_own_last | (r_burst_cnt == CW'(MAX_BURST - 1)));

  assign bus.req_ready        = w_accept_ok ? r_grant : '0;
  assign bus.buf_write_enable = w_xfer;
  assign bus.buf_write_data   = w_own_data;
  assign bus.grant            = r_grant;
  assign bus.grant_id         = r_grant_id;
  assign bus.busy             = w_busy;

  // grant_id survives the return to IDLE and acts as the round-robin pointer.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_grant     <= '0;
      r_grant_id  <= GW'(NUM_REQ - 1);
      r_burst_cnt <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_pick_hit) begin
            r_state     <= S_GRANT;
            r_grant     <= w_pick_onehot;
            r_grant_id  <= w_pick_id;
            r_burst_cnt <= '0;
          end
        end
        S_GRANT: begin
          if (w_burst_end) begin
            r_state     <= S_IDLE;
            r_grant     <= '0;
            r_burst_cnt <= '0;
          end else if (w_xfer) begin
            r_burst_cnt <= r_burst_cnt + CW'(1);
          end
        end
        default: begin
          r_state     <= S_IDLE;
          r_grant     <= '0;
          r_burst_cnt <= '0;
        end
      endcase
    end
  end
endmodule
